prog_rom_loader: RTL
====================

// Module: prog_rom_loader
// PURPOSE
//  16x8 instruction memory feeding the 4-bit CPU fetch path: CPU drives addr (ip), block returns data (opcode|imm) same cycle.
//  Adds a byte-stream load port so a new program can be written at run time without resynthesis.
//  Owns the CPU's reset: holds the CPU in reset while loading, releases it once all 16 bytes are written, so execution restarts at ip=0.
// PARAMETERS
//  DEPTH    16                      program words; must equal 2**AW
//  AW       4                       address width (matches CPU ip)
//  DW       8                       word width (4-bit opcode, 4-bit imm)
//  INIT_IMG lib_cpu::DEFAULT_PROG   DEPTH x DW image restored on n_reset
// PORTS
//  clk          in   1   clock
//  n_reset      in   1   synchronous, active-low reset
//  addr         in   AW  fetch address from CPU
//  data         out  DW  instruction word to CPU
//  load_req     in   1   start/restart a program load (level sampled each cycle)
//  wr_valid     in   1   wr_data valid
//  wr_data      in   DW  program byte, address order 0..DEPTH-1
//  wr_ready     out  1   block accepts wr_data this cycle
//  cpu_n_reset  out  1   registered, drives CPU n_reset
//  load_done    out  1   one-cycle pulse: load complete
//  csum         out  8   mod-256 sum of bytes of last/current load
// BEHAVIOUR
//  Reset (n_reset=0 at clk edge): mem <= INIT_IMG; state=RUN; wptr=0; csum=0; load_done=0; cpu_n_reset=0.
//  data = mem[addr], combinational, zero latency, in every state (reflects contents incl. same-cycle-old value on write).
//  cpu_n_reset registered: next value = (next state == RUN); so CPU leaves reset 1 cycle after n_reset deasserts.
//  wr_ready = (state == LOAD), combinational from state.
//  FSM:
//   RUN:     load_req=1 -> LOAD; wptr<=0; csum<=0; cpu_n_reset<=0. Else stay; wr_valid ignored.
//   LOAD:    load_req=1 -> restart: wptr<=0, csum<=0, same-cycle byte discarded (restart wins).
//            else wr_valid=1: mem[wptr]<=wr_data; csum<=csum+wr_data (8-bit wrap); wptr<=wptr+1.
//            byte written at wptr=DEPTH-1 -> RELEASE (wptr wraps to 0). wr_valid=0 -> hold, no timeout.
//   RELEASE: load_done<=1 for this one cycle (registered, visible in RELEASE); cpu_n_reset stays 0; -> RUN unconditionally.
//            load_req in RELEASE ignored; must be re-asserted in RUN.
//  Sequence after last byte: RELEASE(1 cyc) -> RUN; cpu_n_reset=1 from first RUN cycle edge; CPU fetches addr 0 with new image.
//  Partial load aborted by n_reset: mem fully restored to INIT_IMG, partial bytes lost.
//  Memory words never written in a load keep nothing: a load always rewrites all DEPTH words before release.
//  csum holds after RELEASE until next load start or reset.
// STRUCTURE
//  lib_cpu package: DEFAULT_PROG constant (logic [15:0][7:0]), LOADER_STATE enum {RUN, LOAD, RELEASE}.
//  Single module; memory as register array (needs reset image, so no block RAM inference). No sub-module.
//  Top level wires cpu_n_reset to cpu.n_reset, addr/data to cpu fetch port.
// TESTING
//  1 Reset: hold n_reset=0 3 cyc, release -> cpu_n_reset 0 then 1 next edge; data==INIT_IMG[a] for addr a=0..15.
//  2 Full load: pulse load_req, then bytes 8'h30+i back-to-back -> cpu_n_reset=0 throughout, load_done 1 cyc after 16th byte,
//    csum==8'h78 (sum 0x30..0x3F mod 256), then data[5]==8'h35.
//  3 Gapped valid: same 16 bytes with wr_valid toggling 1/0 -> identical mem and csum; wptr never skips.
//  4 Restart: load 5 bytes, assert load_req with wr_valid=1 -> that byte dropped, next byte lands at addr 0, csum restarts.
//  5 Reset mid-load after 7 bytes -> mem==INIT_IMG, state RUN, load_done never pulses, csum=0.
//  6 Ignored inputs: wr_valid=1 in RUN and load_req during RELEASE -> mem unchanged, FSM returns to RUN.

Source files
------------

// File: rtl/prog_rom_loader_pkg.sv
// Shared types and constants for the program ROM loader and its fetch/load interface.
package prog_rom_loader_pkg;

    localparam int ROM_DEPTH = 16;
    localparam int ROM_AW    = 4;
    localparam int ROM_DW    = 8;
    localparam int CSUM_W    = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } loader_state_e;

    // Power-on program; the last entry in the concatenation is word 0.
    localparam logic [ROM_DEPTH-1:0][ROM_DW-1:0] DEFAULT_PROG = {
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F
    };

endpackage

// File: rtl/prog_rom_loader_if.sv
// CPU fetch port plus byte-stream program load port of the instruction ROM.
interface prog_rom_loader_if
    import prog_rom_loader_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
);
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              load_req;
    logic              wr_valid;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic              cpu_n_reset;
    logic              load_done;
    logic [CSUM_W-1:0] csum;

    modport master (
        output addr, load_req, wr_valid, wr_data,
        input  data, wr_ready, cpu_n_reset, load_done, csum
    );

    modport slave (
        input  addr, load_req, wr_valid, wr_data,
        output data, wr_ready, cpu_n_reset, load_done, csum
    );
endinterface

// File: rtl/prog_rom_loader.sv
// Purpose: 16x8 instruction memory with run-time byte-stream reload; owns the CPU reset.
// Latency: fetch data is combinational (zero cycles); CPU leaves reset one cycle after load/reset ends.
// Backpressure: wr_ready high only while loading; wr_valid may gap arbitrarily, no timeout.
module prog_rom_loader
    import prog_rom_loader_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH,
    parameter int AW    = ROM_AW,
    parameter int DW    = ROM_DW,
    parameter logic [DEPTH-1:0][DW-1:0] INIT_IMG = DEFAULT_PROG
) (
    input logic              clk,
    input logic              n_reset,
    prog_rom_loader_if.slave bus
);

    loader_state_e           state_q, state_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [CSUM_W-1:0]       csum_q, csum_d;
    logic                    load_done_q, cpu_n_reset_q;
    logic                    wr_en;
    logic [DEPTH-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= RUN;
            wptr_q        <= '0;
            csum_q        <= '0;
            load_done_q   <= 1'b0;
            cpu_n_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            csum_q        <= csum_d;
            load_done_q   <= (state_d == RELEASE);
            cpu_n_reset_q <= (state_d == RUN);
        end
    end

    // A load_req while loading restarts the load and beats any same-cycle byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.load_req) state_d = LOAD;
            LOAD:    if (!bus.load_req && bus.wr_valid && wptr_q == AW'(DEPTH - 1))
                         state_d = RELEASE;
            RELEASE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        wptr_d = wptr_q;
        csum_d = csum_q;
        case (state_q)
            RUN: begin
                if (bus.load_req) begin
                    wptr_d = '0;
                    csum_d = '0;
                end
            end
            LOAD: begin
                if (bus.load_req) begin
                    wptr_d = '0;
                    csum_d = '0;
                end else if (bus.wr_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    csum_d = csum_q + CSUM_W'(bus.wr_data);
                end
            end
            default: ;
        endcase
    end

    // Register array rather than RAM: the whole image must be restored on reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            mem_q <= INIT_IMG;
        end else if (wr_en) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    assign bus.data        = mem_q[bus.addr];
    assign bus.wr_ready    = (state_q == LOAD);
    assign bus.cpu_n_reset = cpu_n_reset_q;
    assign bus.load_done   = load_done_q;
    assign bus.csum        = csum_q;

endmodule
